// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback path.
//   NUM_REGS / REG_ADDR_W : architectural register count and index width
//   XLEN                  : register width
//   REG_X0                : hard-wired zero register index
//   STARVE_W              : width of the ALU starvation counter
//   arb_state_e           : writeback arbiter priority state
package rf_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int REG_X0     = 0;
  localparam int STARVE_W   = 4;

  typedef enum logic {
    PRI_LSU = 1'b0,
    PRI_ALU = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rf_wb_grant.sv
// Combinational grant selection for the register-file write port.
//   alu_valid_i/alu_rd_i : ALU writeback request and destination
//   lsu_valid_i/lsu_rd_i : LSU load-return request and destination
//   state_i              : current priority state
//   block_i              : suppress all grants (hold or reset)
//   alu_ready_o/lsu_ready_o : at most one asserted per cycle
//   sel_lsu_o            : write-port mux select (1 = LSU payload)
module rf_wb_grant
  import rf_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              alu_valid_i,
  input  logic [ADDR_W-1:0] alu_rd_i,
  input  logic              lsu_valid_i,
  input  logic [ADDR_W-1:0] lsu_rd_i,
  input  arb_state_e        state_i,
  input  logic              block_i,
  output logic              alu_ready_o,
  output logic              lsu_ready_o,
  output logic              sel_lsu_o
);

  logic collide;

  // Same non-zero destination: the load is older, so it must write first
  // and the ALU result lands last, even when the ALU holds priority.
  assign collide = alu_valid_i && lsu_valid_i &&
                   (alu_rd_i == lsu_rd_i) &&
                   (alu_rd_i != ADDR_W'(REG_X0));

  always_comb begin
    alu_ready_o = 1'b0;
    lsu_ready_o = 1'b0;
    if (!block_i) begin
      if ((state_i == PRI_ALU) && alu_valid_i && !collide) begin
        alu_ready_o = 1'b1;
      end else if (lsu_valid_i) begin
        lsu_ready_o = 1'b1;
      end else if (alu_valid_i) begin
        alu_ready_o = 1'b1;
      end
    end
    sel_lsu_o = lsu_ready_o;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Shares WE/A3/WriteData between the ALU and the LSU load return using
// valid/ready handshakes, discards writes to x0, and bounds ALU starvation.
//   Clk, Rst_n                      : clock, async active-low reset
//   alu_valid/alu_rd/alu_data       : ALU request, alu_ready accepts it
//   lsu_valid/lsu_rd/lsu_data       : LSU request, lsu_ready accepts it
//   hold                            : freeze grants, FSM and starve count
//   rf_we/rf_a3/rf_wd               : registered register-file write
//   x0_drop                         : registered pulse for a discarded x0 write
//   starve_cnt                      : ALU consecutive-denial count
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W     = XLEN,
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int STARVE_MAX = 3
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                lsu_valid,
  input  logic [ADDR_W-1:0]   lsu_rd,
  input  logic [DATA_W-1:0]   lsu_data,
  output logic                lsu_ready,
  input  logic                hold,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_a3,
  output logic [DATA_W-1:0]   rf_wd,
  output logic                x0_drop,
  output logic [STARVE_W-1:0] starve_cnt
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [STARVE_W-1:0] STARVE_TOP = '1;

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
    return (v == STARVE_TOP) ? v : v + 1'b1;
  endfunction

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                x0_q, x0_d;
  logic [ADDR_W-1:0]   a3_q, a3_d;
  logic [DATA_W-1:0]   wd_q, wd_d;

  logic                sel_lsu;
  logic                xfer;
  logic [ADDR_W-1:0]   win_rd;
  logic [DATA_W-1:0]   win_data;

  // Readys are forced low while reset is asserted, not just after the edge.
  rf_wb_grant #(.ADDR_W(ADDR_W)) u_grant (
    .alu_valid_i (alu_valid),
    .alu_rd_i    (alu_rd),
    .lsu_valid_i (lsu_valid),
    .lsu_rd_i    (lsu_rd),
    .state_i     (state_q),
    .block_i     (hold | ~Rst_n),
    .alu_ready_o (alu_ready),
    .lsu_ready_o (lsu_ready),
    .sel_lsu_o   (sel_lsu)
  );

  assign xfer     = alu_ready | lsu_ready;
  assign win_rd   = sel_lsu ? lsu_rd   : alu_rd;
  assign win_data = sel_lsu ? lsu_data : alu_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!hold) begin
      if (alu_ready) begin
        cnt_d = '0;
      end else if (alu_valid) begin
        cnt_d = sat_inc(cnt_q);
      end else if (state_q == PRI_ALU) begin
        // ALU withdrew while it held priority: priority lapses entirely.
        cnt_d = '0;
      end

      case (state_q)
        PRI_LSU: if (cnt_d >= STARVE_LIM) state_d = PRI_ALU;
        PRI_ALU: if (alu_ready || !alu_valid) state_d = PRI_LSU;
        default: state_d = PRI_LSU;
      endcase
    end
  end

  always_comb begin
    we_d = xfer && (win_rd != ADDR_W'(REG_X0));
    x0_d = xfer && (win_rd == ADDR_W'(REG_X0));
    a3_d = we_d ? win_rd   : a3_q;
    wd_d = we_d ? win_data : wd_q;
  end

  // Grant -> register-file write stage boundary (one cycle latency).
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= PRI_LSU;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      x0_q    <= 1'b0;
      a3_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      x0_q    <= x0_d;
      a3_q    <= a3_d;
      wd_q    <= wd_d;
    end
  end

  assign rf_we      = we_q;
  assign rf_a3      = a3_q;
  assign rf_wd      = wd_q;
  assign x0_drop    = x0_q;
  assign starve_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        hold;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic        x0_drop;
  logic [3:0]  starve_cnt;

  int checks   = 0;
  int failures = 0;

  rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(3)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .lsu_valid  (lsu_valid),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .lsu_ready  (lsu_ready),
    .hold       (hold),
    .rf_we      (rf_we),
    .rf_a3      (rf_a3),
    .rf_wd      (rf_wd),
    .x0_drop    (x0_drop),
    .starve_cnt (starve_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        hd;
    logic        e_ar;
    logic        e_lr;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_x0;
    logic [3:0]  e_cnt;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                              input logic hd, input logic e_ar, input logic e_lr,
                              input logic e_we, input logic [4:0] e_a3, input logic [31:0] e_wd,
                              input logic e_x0, input logic [3:0] e_cnt);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat; v.hd = hd;
    v.e_ar = e_ar; v.e_lr = e_lr; v.e_we = e_we; v.e_a3 = e_a3;
    v.e_wd = e_wd; v.e_x0 = e_x0; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //                av ard adat          lv lrd ldat       hd  ar lr  we a3 wd            x0 cnt
    // single ALU write, then idle
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 32'h0,     0,  1, 0,  1, 5, 32'hDEADBEEF, 0, 0);
    vecs[1]  = mk(0, 0, 32'h0,        0, 0, 32'h0,     0,  0, 0,  0, 5, 32'hDEADBEEF, 0, 0);
    // starvation: LSU, LSU, LSU, ALU
    vecs[2]  = mk(1, 3, 32'hA3,       1, 7, 32'hB1,    0,  0, 1,  1, 7, 32'hB1,       0, 1);
    vecs[3]  = mk(1, 3, 32'hA3,       1, 7, 32'hB2,    0,  0, 1,  1, 7, 32'hB2,       0, 2);
    vecs[4]  = mk(1, 3, 32'hA3,       1, 7, 32'hB3,    0,  0, 1,  1, 7, 32'hB3,       0, 3);
    vecs[5]  = mk(1, 3, 32'hA3,       1, 7, 32'hB4,    0,  1, 0,  1, 3, 32'hA3,       0, 0);
    // reach PRI_ALU, then same-destination collision on x9
    vecs[6]  = mk(1, 9, 32'h11,       1, 8, 32'h80,    0,  0, 1,  1, 8, 32'h80,       0, 1);
    vecs[7]  = mk(1, 9, 32'h11,       1, 8, 32'h81,    0,  0, 1,  1, 8, 32'h81,       0, 2);
    vecs[8]  = mk(1, 9, 32'h11,       1, 8, 32'h82,    0,  0, 1,  1, 8, 32'h82,       0, 3);
    vecs[9]  = mk(1, 9, 32'h11,       1, 9, 32'h22,    0,  0, 1,  1, 9, 32'h22,       0, 4);
    vecs[10] = mk(1, 9, 32'h11,       0, 0, 32'h0,     0,  1, 0,  1, 9, 32'h11,       0, 0);
    // LSU write to x0 is accepted but dropped
    vecs[11] = mk(0, 0, 32'h0,        1, 0, 32'hFFFF,  0,  0, 1,  0, 9, 32'h11,       1, 0);
    vecs[12] = mk(0, 0, 32'h0,        0, 0, 32'h0,     0,  0, 0,  0, 9, 32'h11,       0, 0);
    // hold freezes grants and starve count for 3 cycles
    vecs[13] = mk(1, 4, 32'h44,       1, 6, 32'h66,    0,  0, 1,  1, 6, 32'h66,       0, 1);
    vecs[14] = mk(1, 4, 32'h44,       1, 6, 32'h67,    1,  0, 0,  0, 6, 32'h66,       0, 1);
    vecs[15] = mk(1, 4, 32'h44,       1, 6, 32'h67,    1,  0, 0,  0, 6, 32'h66,       0, 1);
    vecs[16] = mk(1, 4, 32'h44,       1, 6, 32'h67,    1,  0, 0,  0, 6, 32'h66,       0, 1);
    vecs[17] = mk(1, 4, 32'h44,       1, 6, 32'h67,    0,  0, 1,  1, 6, 32'h67,       0, 2);
    // PRI_ALU lapses when the ALU withdraws; starve count clears
    vecs[18] = mk(1, 4, 32'h44,       1, 6, 32'h68,    0,  0, 1,  1, 6, 32'h68,       0, 3);
    vecs[19] = mk(0, 0, 32'h0,        1, 6, 32'h69,    0,  0, 1,  1, 6, 32'h69,       0, 0);
    vecs[20] = mk(1, 4, 32'h44,       1, 6, 32'h6A,    0,  0, 1,  1, 6, 32'h6A,       0, 1);

    // Reset held with an ALU request pending
    Rst_n = 1'b0; hold = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'h0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_alu_ready", {31'b0, alu_ready}, 32'd0);
    chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
    chk("rst_rf_a3", {27'b0, rf_a3}, 32'd0);
    chk("rst_rf_wd", rf_wd, 32'd0);
    chk("rst_starve", {28'b0, starve_cnt}, 32'd0);
    Rst_n = 1'b1;
    #1;
    chk("post_rst_alu_ready", {31'b0, alu_ready}, 32'd1);
    @(posedge Clk); #1;
    chk("post_rst_rf_we", {31'b0, rf_we}, 32'd1);
    chk("post_rst_rf_a3", {27'b0, rf_a3}, 32'd1);
    chk("post_rst_rf_wd", rf_wd, 32'h100);

    for (int i = 0; i < NV; i++) begin
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adat;
      lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ldat;
      hold = vecs[i].hd;
      #1;
      chk($sformatf("v%0d_alu_ready", i), {31'b0, alu_ready}, {31'b0, vecs[i].e_ar});
      chk($sformatf("v%0d_lsu_ready", i), {31'b0, lsu_ready}, {31'b0, vecs[i].e_lr});
      @(posedge Clk); #1;
      chk($sformatf("v%0d_rf_we", i), {31'b0, rf_we}, {31'b0, vecs[i].e_we});
      chk($sformatf("v%0d_rf_a3", i), {27'b0, rf_a3}, {27'b0, vecs[i].e_a3});
      chk($sformatf("v%0d_rf_wd", i), rf_wd, vecs[i].e_wd);
      chk($sformatf("v%0d_x0_drop", i), {31'b0, x0_drop}, {31'b0, vecs[i].e_x0});
      chk($sformatf("v%0d_starve", i), {28'b0, starve_cnt}, {28'b0, vecs[i].e_cnt});
    end

    // Reset mid-operation drops the registered write at once
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2222;
    lsu_valid = 1'b0; hold = 1'b0;
    @(posedge Clk); #1;
    chk("midrst_pre_we", {31'b0, rf_we}, 32'd1);
    chk("midrst_pre_a3", {27'b0, rf_a3}, 32'd2);
    Rst_n = 1'b0;
    #1;
    chk("midrst_we", {31'b0, rf_we}, 32'd0);
    chk("midrst_a3", {27'b0, rf_a3}, 32'd0);
    chk("midrst_alu_ready", {31'b0, alu_ready}, 32'd0);
    chk("midrst_starve", {28'b0, starve_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Writeback arbiter and sequencer for the register file's single synchronous write port (WE/A3/WriteData). Shares that port between two requesters, the ALU writeback and the load/store unit (LSU) load-return, using valid/ready handshakes. Enforces x0 write suppression, because the register file itself does not protect x0. Provides starvation-bounded priority and drives registered write controls to the register file one cycle after grant.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, register index width (32 architectural registers)
STARVE_MAX, 3, consecutive denied cycles after which ALU gains priority (1..15)

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU writeback request
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU request accepted this cycle (combinational)
lsu_valid  in  1  LSU load-return request
lsu_rd  in  ADDR_W  LSU destination register
lsu_data  in  DATA_W  load data
lsu_ready  out  1  LSU request accepted this cycle (combinational)
hold  in  1  freeze all grants (debug/flush)
rf_we  out  1  register file write enable (registered)
rf_a3  out  ADDR_W  register file write address (registered)
rf_wd  out  DATA_W  register file write data (registered)
x0_drop  out  1  pulse: accepted request targeted x0 and was discarded (registered)
starve_cnt  out  4  current ALU starvation count (status)

Behaviour:
- Reset (Rst_n low, async): rf_we=0, rf_a3=0, rf_wd=0, x0_drop=0, starve_cnt=0, FSM=PRI_LSU. alu_ready and lsu_ready are 0 while Rst_n is low.
- Handshake: a transfer occurs when valid && ready are both high at a rising edge. A requester holds valid, rd and data stable until ready. ready depends only on the valids, the rds, hold and the FSM state; it never depends on data.
- Grants: at most one ready per cycle. hold=1 forces both readys to 0 and freezes the FSM and starve_cnt.
- FSM states:
  - PRI_LSU: LSU wins if lsu_valid; otherwise ALU wins if alu_valid.
  - PRI_ALU: ALU wins if alu_valid; otherwise LSU wins.
- starve_cnt:
  - Increments (saturating at 15) each cycle alu_valid=1 and alu_ready=0.
  - Clears on an ALU grant.
  - Unchanged when alu_valid=0.
- Transitions:
  - PRI_LSU -> PRI_ALU when the next starve_cnt value >= STARVE_MAX.
  - PRI_ALU -> PRI_LSU after any ALU grant.
  - PRI_ALU also returns to PRI_LSU if alu_valid drops without a grant; starve_cnt clears in that case.
- Same-destination collision: both valid with alu_rd == lsu_rd != 0. The LSU is granted first regardless of FSM state. The load is older, and the ALU write must land last. The PRI_ALU override is suppressed for that cycle, and starve_cnt still increments.
- Output latency: 1 cycle. The edge that completes a transfer loads rf_we=1, rf_a3=rd, rf_wd=data. With no transfer, rf_we=0; rf_a3/rf_wd hold their last values.
- x0 suppression: a granted request with rd==0 completes the handshake normally (ready=1) but produces rf_we=0 and x0_drop=1 for one cycle. x0_drop=0 otherwise.
- Back-to-back: a new grant is allowed every cycle. Sustained throughput is 1 write/cycle.
- Reset mid-operation: in-flight registered write is dropped (rf_we=0 immediately). Requesters must re-present after reset.
- hold asserted on the same cycle as a pending output: the already-registered write still appears; only new grants are blocked.

Decomposition:
- Shared package rf_pkg:
  - localparams NUM_REGS=32, REG_ADDR_W=5, XLEN=32, REG_X0=0
  - enum for arbiter states PRI_LSU/PRI_ALU
- Sub-module rf_wb_grant: purely combinational grant selection from valids, rds, state and hold, producing alu_ready/lsu_ready/sel.
- The top holds the FSM, starve_cnt and the output registers.

Test Plan:
1. Reset with Rst_n low while alu_valid=1 -> alu_ready=0, rf_we=0, starve_cnt=0. Release reset -> ALU granted; next edge rf_we=1, rf_a3=alu_rd.
2. ALU only, rd=5, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF. Following cycle rf_we=0.
3. Both valid for 4 cycles, rd 3 vs 7, STARVE_MAX=3, LSU presenting new loads each cycle -> grants in order LSU, LSU, LSU, ALU; starve_cnt goes 1, 2, 3, 0.
4. Collision, both rd=9 with ALU data=0x11 and LSU data=0x22, state PRI_ALU -> LSU granted first, ALU next. rf writes in order (9, 0x22) then (9, 0x11).
5. LSU request with rd=0, data=0xFFFF -> lsu_ready=1; next cycle rf_we=0, x0_drop=1.
6. hold=1 for 3 cycles with both valid -> no readys, starve_cnt frozen. Drop hold -> normal grant resumes on the same edge.
